// File: rtl/sine_dds_source_if.sv
// rtl/sine_dds_source_if.sv - quarter-wave ROM bus and sample handshake of the DDS source
interface sine_dds_source_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
);
  logic [ADDR_W-1:0] rom_addr;
  logic [DATA_W-2:0] rom_data;
  logic [DATA_W-1:0] sample;
  logic              sample_valid;
  logic              sample_ready;

  modport master (
    output rom_addr,
    input  rom_data,
    output sample,
    output sample_valid,
    input  sample_ready
  );

  modport slave (
    input  rom_addr,
    output rom_data,
    input  sample,
    input  sample_valid,
    output sample_ready
  );
endinterface

// File: rtl/sine_dds_source.sv
// rtl/sine_dds_source.sv - DDS sample source: phase accumulator, quarter-wave fold, sample handshake
module sine_dds_source #(
  parameter int PHASE_W  = 16,
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 8,
  parameter int TICK_DIV = 1000
) (
  input  logic               clk_100,
  input  logic               rst,
  input  logic               en_i,
  input  logic [PHASE_W-1:0] phase_inc_i,
  input  logic               load_inc_i,
  output logic               overrun_o,
  sine_dds_source_if.master  bus
);

  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TICK_DIV - 1);
  localparam logic [DATA_W-1:0] MID      = DATA_W'(1) << (DATA_W - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ADDR,
    S_DATA,
    S_HOLD
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [PHASE_W-1:0] phase_q, phase_d;
  logic [PHASE_W-1:0] inc_q, inc_d;
  logic [1:0]         quad_q, quad_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [DATA_W-1:0]  sample_q, sample_d;
  logic               valid_q, valid_d;
  logic               ovr_q, ovr_d;

  logic               tick;
  logic [ADDR_W-1:0]  idx;
  logic [DATA_W-1:0]  rom_ext;

  assign tick    = en_i && (cnt_q == CNT_LAST);
  assign idx     = phase_q[PHASE_W-3 -: ADDR_W];
  assign rom_ext = {1'b0, bus.rom_data};

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    phase_d  = phase_q;
    inc_d    = inc_q;
    quad_d   = quad_q;
    addr_d   = addr_q;
    sample_d = sample_q;
    valid_d  = valid_q;
    ovr_d    = ovr_q;

    if (en_i) begin
      cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
    end
    if (load_inc_i) begin
      inc_d = phase_inc_i;
    end
    // The phase advances on every tick, serviced or dropped, so output frequency is preserved.
    if (tick) begin
      phase_d = phase_q + inc_q;
    end

    unique case (state_q)
      S_IDLE: begin
        if (tick) begin
          quad_d  = phase_q[PHASE_W-1 -: 2];
          addr_d  = phase_q[PHASE_W-2] ? ~idx : idx;
          state_d = S_ADDR;
        end
      end
      S_ADDR: state_d = S_DATA;
      S_DATA: begin
        sample_d = quad_q[1] ? (MID - rom_ext) : (MID + rom_ext);
        valid_d  = 1'b1;
        state_d  = S_HOLD;
      end
      S_HOLD: begin
        if (bus.sample_ready) begin
          valid_d = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (tick && (state_q != S_IDLE)) begin
      ovr_d = 1'b1;
    end
  end

  always_ff @(posedge clk_100) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      phase_q  <= '0;
      inc_q    <= '0;
      quad_q   <= '0;
      addr_q   <= '0;
      sample_q <= MID;
      valid_q  <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      phase_q  <= phase_d;
      inc_q    <= inc_d;
      quad_q   <= quad_d;
      addr_q   <= addr_d;
      sample_q <= sample_d;
      valid_q  <= valid_d;
      ovr_q    <= ovr_d;
    end
  end

  assign bus.rom_addr     = addr_q;
  assign bus.sample       = sample_q;
  assign bus.sample_valid = valid_q;
  assign overrun_o        = ovr_q;

endmodule

// File: tb/tb_sine_dds_source.sv
// tb/tb_sine_dds_source.sv - randomized and directed bench for sine_dds_source against a cycle reference model
module tb_sine_dds_source;

  localparam int TD = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        load_inc;
  logic [15:0] phase_inc;
  logic        ready;
  logic        overrun;
  logic        chk_en = 1'b0;
  logic        prev_v = 1'b0;
  int          n_chk = 0;
  int          n_err = 0;

  logic [6:0]  rom [256];
  logic [15:0] rec_q [$];

  sine_dds_source_if #(.ADDR_W(8), .DATA_W(8)) bus ();

  sine_dds_source #(.PHASE_W(16), .ADDR_W(8), .DATA_W(8), .TICK_DIV(TD)) dut (
    .clk_100     (clk),
    .rst         (rst),
    .en_i        (en),
    .phase_inc_i (phase_inc),
    .load_inc_i  (load_inc),
    .overrun_o   (overrun),
    .bus         (bus)
  );

  always #5 clk = ~clk;

  assign bus.sample_ready = ready;
  always @(posedge clk) bus.rom_data <= rom[bus.rom_addr];

  // Reference model: transaction-level view of a conversion started by a tick.
  int          m_cnt;
  int          m_t;
  logic [15:0] m_phase, m_inc;
  logic [7:0]  m_addr, m_sample, m_pend;
  bit          m_busy, m_valid, m_ovr;

  function automatic logic [7:0] ref_addr(input logic [15:0] ph);
    int pos = (int'(ph) >> 6) & 255;
    int q   = int'(ph) >> 14;
    return (q % 2 == 1) ? 8'(255 - pos) : 8'(pos);
  endfunction

  function automatic logic [7:0] ref_sample(input logic [15:0] ph);
    int q = int'(ph) >> 14;
    int r = int'(rom[ref_addr(ph)]);
    return (q < 2) ? 8'(128 + r) : 8'(128 - r);
  endfunction

  always @(posedge clk) begin : model
    bit tk, ob, ov;
    if (rst) begin
      m_cnt = 0; m_t = 0; m_phase = 0; m_inc = 0;
      m_addr = 0; m_sample = 128; m_pend = 128;
      m_busy = 0; m_valid = 0; m_ovr = 0;
    end else begin
      tk = en && (m_cnt == TD - 1);
      ob = m_busy;
      ov = m_valid;
      if (ov && ready) begin
        m_valid = 0;
        m_busy  = 0;
      end else if (ob && !ov) begin
        m_t++;
        if (m_t == 2) begin
          m_valid  = 1;
          m_sample = m_pend;
        end
      end
      if (tk) begin
        if (!ob) begin
          m_busy = 1;
          m_t    = 0;
          m_addr = ref_addr(m_phase);
          m_pend = ref_sample(m_phase);
        end else begin
          m_ovr = 1;
        end
        m_phase = m_phase + m_inc;
      end
      if (en) m_cnt = (m_cnt + 1) % TD;
      if (load_inc) m_inc = phase_inc;
    end
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("rom_addr", 32'(bus.rom_addr), 32'(m_addr));
      check("sample_valid", 32'(bus.sample_valid), 32'(m_valid));
      check("sample", 32'(bus.sample), 32'(m_sample));
      check("overrun", 32'(overrun), 32'(m_ovr));
      if (bus.sample_valid && !prev_v) rec_q.push_back({bus.rom_addr, bus.sample});
      prev_v = bus.sample_valid;
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1; en = 0; load_inc = 0;
    @(negedge clk);
    rst = 0;
    rec_q.delete();
  endtask

  task automatic load(input logic [15:0] v);
    phase_inc = v; load_inc = 1;
    @(negedge clk);
    load_inc = 0;
  endtask

  // Returns at the negedge just before an edge on which the tick fires.
  task automatic wait_tick();
    int n = 0;
    while (!(en && m_cnt == TD - 1) && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) check("tick_timeout", 1, 0);
  endtask

  task automatic wait_recs(input int want, input int bound);
    int n = 0;
    while (rec_q.size() < want && n < bound) begin
      @(negedge clk);
      n++;
    end
    check("rec_count", 32'(rec_q.size()), 32'(want));
  endtask

  task automatic check_rec(input int i, input logic [7:0] a, input logic [7:0] s);
    logic [15:0] r;
    r = (i < rec_q.size()) ? rec_q[i] : 16'hxxxx;
    check("rec_addr", 32'(r[15:8]), 32'(a));
    check("rec_sample", 32'(r[7:0]), 32'(s));
  endtask

  initial begin
    logic [7:0] exp_a [5];
    logic [7:0] exp_s [5];
    rst = 1; en = 0; load_inc = 0; phase_inc = 0; ready = 1;
    for (int k = 0; k < 256; k++) rom[k] = 7'(k);
    repeat (2) @(negedge clk);
    chk_en = 1;
    check("rst_valid", 32'(bus.sample_valid), 0);
    check("rst_sample", 32'(bus.sample), 128);
    check("rst_addr", 32'(bus.rom_addr), 0);
    check("rst_overrun", 32'(overrun), 0);

    // Zero increment: phase stays at 0
    do_reset();
    en = 1; ready = 1;
    wait_recs(3, 40);
    for (int i = 0; i < 3; i++) check_rec(i, 8'd0, 8'd128);

    // Quarter-turn increment walks all four quadrants
    do_reset();
    en = 1;
    load(16'h4000);
    wait_recs(5, 60);
    exp_a = '{8'd0, 8'd255, 8'd0, 8'd255, 8'd0};
    exp_s = '{8'd128, 8'd255, 8'd128, 8'd1, 8'd128};
    for (int i = 0; i < 5; i++) check_rec(i, exp_a[i], exp_s[i]);

    // Stalled downstream: overrun sticks
    do_reset();
    ready = 0; en = 1;
    load(16'h0100);
    repeat (12) @(negedge clk);
    check("stall_valid", 32'(bus.sample_valid), 1);
    check("stall_sample", 32'(bus.sample), 128);
    check("stall_overrun", 32'(overrun), 1);
    ready = 1;
    @(negedge clk);
    check("accept_valid", 32'(bus.sample_valid), 0);
    check("accept_overrun", 32'(overrun), 1);

    // Increment load on the tick edge: old increment applies to that tick
    do_reset();
    ready = 1; en = 1;
    load(16'h0100);
    wait_tick(); @(negedge clk);
    wait_tick(); @(negedge clk);
    wait_tick();
    phase_inc = 16'h0200; load_inc = 1;
    @(negedge clk);
    load_inc = 0;
    wait_recs(5, 60);
    exp_a = '{8'd0, 8'd4, 8'd8, 8'd12, 8'd20};
    for (int i = 0; i < 5; i++) check_rec(i, exp_a[i], 8'(128 + exp_a[i]));

    // Enable dropped during ADDR: conversion completes, then everything freezes
    do_reset();
    ready = 1; en = 1;
    load(16'h0100);
    wait_tick(); @(negedge clk);
    en = 0;
    repeat (12) @(negedge clk);
    check("frozen_recs", 32'(rec_q.size()), 1);
    en = 1;
    wait_recs(2, 20);
    check_rec(1, 8'd4, 8'd132);

    // Reset while in DATA
    do_reset();
    ready = 0; en = 1;
    load(16'h1000);
    repeat (10) @(negedge clk);
    check("pre_rst_overrun", 32'(overrun), 1);
    ready = 1;
    @(negedge clk);
    wait_tick(); @(negedge clk);
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    check("data_rst_valid", 32'(bus.sample_valid), 0);
    check("data_rst_sample", 32'(bus.sample), 128);
    check("data_rst_addr", 32'(bus.rom_addr), 0);
    check("data_rst_overrun", 32'(overrun), 0);
    rst = 0;
    rec_q.delete();
    wait_recs(1, 20);
    check_rec(0, 8'd0, 8'd128);

    // Randomized traffic with a random ROM image
    @(negedge clk);
    rst = 1;
    for (int k = 0; k < 256; k++) rom[k] = 7'($urandom);
    @(negedge clk);
    rst = 0;
    for (int c = 0; c < 3000; c++) begin
      en        = ($urandom_range(0, 7) != 0);
      ready     = ($urandom_range(0, 2) != 0);
      load_inc  = ($urandom_range(0, 15) == 0);
      phase_inc = 16'($urandom);
      rst       = ($urandom_range(0, 499) == 0);
      @(negedge clk);
    end
    rst = 0; load_inc = 0;
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/sine_dds_source.md
Name: sine_dds_source

Overview:
- Direct-digital-synthesis sample source, directly upstream of the 1-bit sine modulator.
- Runs a phase accumulator at a programmable sample rate and folds the phase into quarter-wave ROM addresses.
- Rebuilds full-wave offset-binary samples from the ROM data and hands each sample downstream over a valid/ready handshake.
- The quarter-wave ROM is external, read synchronously with 1-cycle latency.

Parameters:
- PHASE_W, 16, phase accumulator width.
- ADDR_W, 8, quarter-table address width; table depth is 2^ADDR_W.
- DATA_W, 8, output sample width, offset binary.
- TICK_DIV, 1000, clk_100 cycles per sample tick; legal range is 4 or more.

Ports:
- clk_100  in  1  100 MHz system clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- en  in  1  run enable.
- phase_inc  in  PHASE_W  new phase increment.
- load_inc  in  1  one-cycle strobe; captures phase_inc.
- rom_addr  out  ADDR_W  quarter-table read address.
- rom_data  in  DATA_W-1  table word; valid 1 cycle after rom_addr.
- sample  out  DATA_W  sample value.
- sample_valid  out  1  sample available.
- sample_ready  in  1  downstream accepts sample.
- overrun  out  1  sticky flag: a tick was dropped.

Behaviour:
- Reset values (rst=1 at an edge): phase=0, inc=0, tick counter=0, state=IDLE, rom_addr=0, sample=2^(DATA_W-1), sample_valid=0, overrun=0.
- rst has priority over everything, including a transaction in flight. All outputs hold reset values the cycle after rst is sampled.
- Tick counter:
  - Advances only while en=1.
  - Counts 0..TICK_DIV-1 and wraps to 0.
  - The internal tick is asserted in the cycle the count equals TICK_DIV-1.
  - en=0 freezes the counter and the phase; a transaction already in flight still completes.
- load_inc: inc <= phase_inc at the next edge. The new value is first used at the next tick. If load_inc and a tick land on the same edge, the old inc is used for that tick.
- On every tick: phase <= phase + inc, modulo 2^PHASE_W with natural wrap. The tick converts the phase value from before the add.
- Address fold:
  - quad = phase[PHASE_W-1:PHASE_W-2]
  - idx = phase[PHASE_W-3 -: ADDR_W]
  - quad 0 and 2 use addr=idx; quad 1 and 3 use addr=~idx (bitwise mirror).
- Reconstruct, with mid=2^(DATA_W-1):
  - quad 0 and 1: sample = mid + rom_data.
  - quad 2 and 3: sample = mid - rom_data.
  - ROM contents are 0..2^(DATA_W-1)-1, so the result never overflows.
- FSM: IDLE -> ADDR -> DATA -> HOLD -> IDLE.
  - IDLE: on tick, latch quad, register rom_addr, go to ADDR.
  - ADDR: rom_addr held stable; go to DATA.
  - DATA: capture rom_data, register sample, set sample_valid=1, go to HOLD.
  - HOLD: sample and sample_valid are held. When sample_ready=1 at an edge, sample_valid <= 0 and the state returns to IDLE.
  - An accept and a new tick on the same edge: the tick is not serviced (state is not IDLE), so it counts as a drop.
- Latency: tick at cycle T gives rom_addr valid at T+1 and sample_valid=1 at T+3.
- Drop rule: a tick arriving while state is not IDLE sets overrun=1 and is not converted, but the phase still advances, so frequency is preserved.
- overrun clears only on rst.
- sample holds its last value after acceptance until the next conversion.

Test Plan:
- Use TICK_DIV=4, ADDR_W=8, DATA_W=8, PHASE_W=16 for all tests.
1. Reset, then en=1, inc=0, ready=1, ROM[k]=k -> first tick gives rom_addr=0 and sample=128 with valid at tick+3. Valid lasts 1 cycle, and the pattern repeats every 4 cycles with phase stuck at 0.
2. load inc=0x4000, ready=1 -> the first tick after the load converts phase 0x0000 and phase becomes 0x4000. Successive conversions use phases 0x0000, 0x4000, 0x8000, 0xC000, 0x0000. The quadrant sequence is 0,1,2,3,0 with rom_addr 0,255,0,255,0 and samples 128,255,128,1,128 (ROM[k]=k). Phase wraps to 0 after 0xC000 with no glitch.
3. inc=0x0100, ready held 0 -> valid stays 1 with sample constant. overrun goes 1 on the next tick; phase still advances 0x0100 per tick. Raise ready -> valid drops the next cycle and overrun stays 1.
4. load_inc on the same edge as a tick, changing 0x0100 to 0x0200 -> that tick adds 0x0100 and the following tick adds 0x0200.
5. en=0 during ADDR -> the transaction completes (valid at the usual cycle), then no further ticks occur and phase and counter are frozen. Set en=1 -> counting resumes from the held value.
6. rst=1 in DATA state with valid about to rise -> next cycle valid=0, sample=128, rom_addr=0, overrun=0, phase=0.
